signed_divider: RTL and testbench

- Sequential 8-bit signed integer divider; the inverse companion to the team's signed shift-add multiplier.
- Converts operands to magnitudes with two's complement, then runs a restoring shift-subtract loop, one quotient bit per clock.
- Finally applies signs and flags, and reports the result with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath and feeds the same result/display path.

---
 rtl/signed_divider.sv | 195 +++++++++++++++++++
 tb/tb_signed_divider.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// signed_divider: sequential two's complement divider, one quotient bit per clock.
//
// Operands are reduced to magnitudes on the accepting edge, then divided with a restoring
// shift-subtract loop. Signs and flags are applied in a final FIX cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   start        request, sampled only while idle
//   dividend     signed dividend, captured on the accepting edge
//   divisor      signed divisor, captured on the accepting edge
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, same sign as the dividend
//   busy         high from the accepting edge until done
//   done         one-cycle pulse when results are valid
//   sign         quotient is negative
//   zero_flag    quotient is zero
//   div_by_zero  divisor was zero
//   overflow     quotient not representable (MIN / -1 only)
module signed_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic             zero_flag,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned     CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic             qsign_q, qsign_d;    // quotient sign
    logic             rsign_q, rsign_d;    // remainder sign (dividend sign)
    logic             dz_q, dz_d;          // divide-by-zero pending for FIX
    logic [WIDTH-1:0] q_q, q_d;            // working quotient, starts as |dividend|
    logic [WIDTH-1:0] dvs_q, dvs_d;        // |divisor|
    // The remainder is always below |divisor| <= 2^(WIDTH-1), so WIDTH bits hold it;
    // the extra bit of the working remainder only exists in the shifted value.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        // MIN maps onto itself, which reads correctly as the unsigned 2^(WIDTH-1).
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign rem_shift = {rem_q, q_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    always_comb begin
        state_d     = state_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        dz_d        = dz_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sign_d      = sign_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rsign_d = dividend[WIDTH-1];
                    dvs_d   = mag(divisor);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    if (divisor == '0) begin
                        // Quotient 0, remainder |dividend|: FIX then restores the dividend.
                        dz_d    = 1'b1;
                        q_d     = '0;
                        rem_d   = mag(dividend);
                        state_d = StFix;
                    end else begin
                        dz_d    = 1'b0;
                        q_d     = mag(dividend);
                        rem_d   = '0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (trial[WIDTH]) begin
                    rem_d = rem_shift[WIDTH-1:0];
                end else begin
                    rem_d = trial[WIDTH-1:0];
                end
                q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFix: begin
                quotient_d  = qsign_q ? -q_q : q_q;
                remainder_d = rsign_q ? -rem_q : rem_q;
                zero_d      = (q_q == '0);
                sign_d      = qsign_q & (q_q != '0);
                ovf_d       = (q_q > MAXPOS) & ~qsign_q;
                dbz_d       = dz_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            dz_q        <= 1'b0;
            q_q         <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            dz_q        <= dz_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sign        = sign_q;
    assign zero_flag   = zero_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Bench for signed_divider: integer-arithmetic reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic including resets.
module tb_signed_divider;

    localparam int W = 8;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       sgn;
        logic       zr;
        logic       dbz;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic [7:0] quotient, remainder;
    logic       busy, done, sign, zero_flag, div_by_zero, overflow;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    signed_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .sign       (sign),
        .zero_flag  (zero_flag),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference result from plain integer division (SV truncates toward zero).
    function automatic res_t ref_div(input logic [7:0] a, input logic [7:0] b);
        res_t res;
        int sa, sb, iq, ir;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            iq = 0;
            ir = sa;
        end else begin
            iq = sa / sb;
            ir = sa % sb;
        end
        res.q   = iq[7:0];
        res.r   = ir[7:0];
        res.ovf = (iq > 127);
        res.sgn = (iq < 0);
        res.zr  = (iq == 0);
        res.dbz = (sb == 0);
        return res;
    endfunction

    function automatic logic [7:0] pick();
        logic [7:0] v;
        case ($urandom_range(0, 7))
            0: v = 8'h00;
            1: v = 8'h80;
            2: v = 8'hFF;
            3: v = 8'h01;
            4: v = 8'h7F;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level timing model: a result lands 9 edges after acceptance (1 for divide by zero).
    res_t m = '0;
    res_t pend = '0;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    int   left = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m      <= '0;
            pend   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (left > 0) begin
                left <= left - 1;
                if (left == 1) begin
                    m      <= pend;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (start) begin
                pend   <= ref_div(dividend, divisor);
                m_busy <= 1'b1;
                m.ovf  <= 1'b0;
                m.dbz  <= 1'b0;
                left   <= (divisor == 8'h00) ? 1 : W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("quotient", quotient, m.q);
            check("remainder", remainder, m.r);
            check("sign", sign, m.sgn);
            check("zero_flag", zero_flag, m.zr);
            check("div_by_zero", div_by_zero, m.dbz);
            check("overflow", overflow, m.ovf);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input int lat);
        int n;
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 8'($urandom);
        wait_done(n);
        check("latency", n, lat);
    endtask

    task automatic expect_res(input string name, input logic [7:0] q, input logic [7:0] r,
                              input logic sg, input logic zr, input logic dz, input logic ov);
        check({name, "_q"}, quotient, q);
        check({name, "_r"}, remainder, r);
        check({name, "_sign"}, sign, sg);
        check({name, "_zero"}, zero_flag, zr);
        check({name, "_dbz"}, div_by_zero, dz);
        check({name, "_ovf"}, overflow, ov);
    endtask

    initial begin
        res_t t;
        int   n;
        int   seen_done;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        expect_res("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b1;

        // Pin the model to hand-computed values.
        t = ref_div(8'd100, 8'd7);
        check("ref_100_7_q", t.q, 8'h0E);
        check("ref_100_7_r", t.r, 8'h02);
        t = ref_div(8'h9C, 8'hF9);
        check("ref_m100_m7_q", t.q, 8'h0E);
        check("ref_m100_m7_r", t.r, 8'hFE);
        t = ref_div(8'h80, 8'hFF);
        check("ref_min_m1_q", t.q, 8'h80);
        check("ref_min_m1_ovf", t.ovf, 1'b1);

        op(8'd100, 8'd7, 9);
        expect_res("p100_7", 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        op(8'h9C, 8'd7, 9);
        expect_res("m100_7", 8'hF2, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        op(8'h9C, 8'hF9, 9);
        expect_res("m100_m7", 8'h0E, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        op(8'd3, 8'hF6, 9);
        expect_res("p3_m10", 8'h00, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        op(8'h80, 8'hFF, 9);
        expect_res("min_m1", 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        op(8'h80, 8'h01, 9);
        expect_res("min_1", 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        op(8'd5, 8'h00, 1);
        expect_res("p5_0", 8'h00, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0);
        op(8'd20, 8'd4, 9);
        expect_res("p20_4", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // start while busy is ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 8'd100;
        divisor = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        expect_res("busy_start", 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset mid-operation aborts without a done pulse
        @(posedge clk);
        #1;
        start = 1'b1;
        dividend = 8'd100;
        divisor = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_res("abort", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_busy", busy, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        op(8'd50, 8'd5, 9);
        expect_res("p50_5", 8'h0A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional reset; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 3) == 0);
            dividend = pick();
            divisor = pick();
        end

        // start held high: back-to-back restarts
        rst = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            dividend = pick();
            divisor = pick();
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
